// File: rtl/mips_harvard_mem_responder.sv
// Instruction/data memory responder for the Harvard MIPS CPU, with optional
// data wait states (enable with `define MEM_RESPONDER_WAIT_EN).
module mips_harvard_mem_responder #(
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h00000000,
  parameter int unsigned DATA_WORDS  = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        err,
  output logic [15:0] access_count
);

  localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];

  logic [31:0] i_off_s, ii_s, d_off_s, di_s;
  logic        i_ok_s, d_ok_s, d_req_s, conflict_s, bad_s;
  logic        ce_s, done_s, drop_s, commit_s;
  logic        err_q, err_d;
  logic [15:0] access_count_q, access_count_d;

  // Address decode and the combinational read ports
  always_comb begin
    i_off_s    = instr_address - INSTR_BASE;
    ii_s       = {2'b00, i_off_s[31:2]};
    i_ok_s     = (ii_s < INSTR_WORDS) && (instr_address[1:0] == 2'b00);
    d_off_s    = data_address - DATA_BASE;
    di_s       = {2'b00, d_off_s[31:2]};
    d_ok_s     = (di_s < DATA_WORDS) && (data_address[1:0] == 2'b00);
    d_req_s    = data_read | data_write;
    conflict_s = data_read & data_write;
    bad_s      = !i_ok_s || (d_req_s && (!d_ok_s || conflict_s));
    if (i_ok_s) begin
      instr_readdata = imem[ii_s[IAW-1:0]];
    end else begin
      instr_readdata = 32'h0;
    end
    // A conflicting request is a write, so it never returns read data
    if (data_read && !data_write && d_ok_s) begin
      data_readdata = dmem[di_s[DAW-1:0]];
    end else begin
      data_readdata = 32'h0;
    end
  end

`ifdef MEM_RESPONDER_WAIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GO = 2'd2} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Wait-state sequencing; the request cycle itself is the first stalled cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_s    = 1'b1;
    done_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req_s && (WAIT_CNT == 4'd0)) begin
          done_s = 1'b1;
        end else if (d_req_s) begin
          ce_s  = 1'b0;
          cnt_d = WAIT_CNT - 4'd1;
          // A single wait state is covered by the request cycle alone
          if (WAIT_CNT == 4'd1) begin
            state_d = S_GO;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        ce_s = 1'b0;
        if (!d_req_s) begin
          drop_s  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_GO;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WAIT;
        end
      end
      S_GO: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Wait-state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Without wait states every request completes in its own cycle
  always_comb begin
    ce_s   = 1'b1;
    done_s = d_req_s;
    drop_s = 1'b0;
  end
`endif

  // Stall output, write qualification and status next-state
  always_comb begin
    if (reset) begin
      clk_enable = 1'b1;
    end else begin
      clk_enable = ce_s;
    end
    commit_s = !reset && ce_s && data_write && d_ok_s;
    err_d    = err_q | bad_s | drop_s;
    if (done_s) begin
      access_count_d = access_count_q + 16'd1;
    end else begin
      access_count_d = access_count_q;
    end
  end

  // Sticky error flag and completed-access counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q          <= 1'b0;
      access_count_q <= 16'd0;
    end else begin
      err_q          <= err_d;
      access_count_q <= access_count_d;
    end
  end

  // Data array write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (commit_s) begin
      dmem[di_s[DAW-1:0]] <= data_writedata;
    end
  end

  assign err          = err_q;
  assign access_count = access_count_q;

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
// Randomized self-checking bench for mips_harvard_mem_responder against a
// transaction-level model (each access takes EW+1 cycles, EW stalled).
module tb_mips_harvard_mem_responder;

  localparam logic [31:0] IB     = 32'hBFC00000;
  localparam logic [31:0] DB     = 32'h00000000;
  localparam int          IWORDS = 1024;
  localparam int          DWORDS = 1024;
  localparam int          WAITC  = 2;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int          EW     = WAITC;
`else
  localparam int          EW     = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_read, data_write, clk_enable, err;
  logic [15:0] access_count;

  mips_harvard_mem_responder #(
    .INSTR_BASE(IB), .INSTR_WORDS(IWORDS), .DATA_BASE(DB),
    .DATA_WORDS(DWORDS), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .clk_enable(clk_enable), .err(err), .access_count(access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DWORDS];
  bit          known   [DWORDS];
  logic [31:0] iref    [16];
  logic [15:0] exp_count;
  bit          exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - DB;
    return (a[1:0] == 2'b00) && ((off >> 2) < DWORDS);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    data_read = 1'b0;
    data_write = 1'b0;
    #1;
    check_eq("ce_in_reset", {31'b0, clk_enable}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_err = 1'b0;
    exp_count = 16'd0;
    #1;
    check_eq("ce_after_reset", {31'b0, clk_enable}, 32'd1);
    check_eq("err_after_reset", {31'b0, err}, 32'd0);
    check_eq("count_after_reset", {16'b0, access_count}, 32'd0);
  endtask

  // One CPU data access, held until the model says it has completed
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd);
    bit          ok, chk;
    int unsigned idx;
    logic [31:0] exp_rd;
    ok  = addr_ok(addr);
    idx = (addr - DB) >> 2;
    exp_rd = 32'h0;
    chk = 1'b1;
    if (rd && !wr && ok) begin
      if (known[idx]) exp_rd = ref_mem[idx];
      else chk = 1'b0;
    end
    data_read = rd;
    data_write = wr;
    data_address = addr;
    data_writedata = wd;
    for (int k = 0; k <= EW; k++) begin
      #2;
      check_eq("clk_enable", {31'b0, clk_enable}, (k == EW) ? 32'd1 : 32'd0);
      if (chk) check_eq("data_readdata", data_readdata, exp_rd);
      @(posedge clk); #1;
    end
    data_read = 1'b0;
    data_write = 1'b0;
    exp_count = exp_count + 16'd1;
    if (wr && ok) begin
      ref_mem[idx] = wd;
      known[idx] = 1'b1;
    end
    if (!ok || (rd && wr)) exp_err = 1'b1;
    check_eq("access_count", {16'b0, access_count}, {16'b0, exp_count});
    check_eq("err", {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [16];
    logic [31:0] v1, v2;
    int          sel;
    reset = 1'b1;
    instr_address = IB;
    data_address = DB;
    data_writedata = 32'h0;
    data_read = 1'b0;
    data_write = 1'b0;
    exp_count = 16'd0;
    exp_err = 1'b0;
    for (int i = 0; i < DWORDS; i++) known[i] = 1'b0;
    iref[0] = 32'h24020005;
    for (int i = 1; i < 16; i++) iref[i] = $urandom;
    for (int i = 0; i < 16; i++) dut.imem[i] = iref[i];
    for (int i = 0; i < 16; i++)
      addrs[i] = DB + 32'((i < 8) ? i * 4 : (DWORDS - 16 + i) * 4);

    do_reset();

    // Instruction fetches
    instr_address = IB;
    #1;
    check_eq("fetch0", instr_readdata, 32'h24020005);
    for (int n = 0; n < 8; n++) begin
      sel = $urandom_range(0, 15);
      instr_address = IB + 32'(sel * 4);
      #1;
      check_eq("fetch", instr_readdata, iref[sel]);
    end
    instr_address = IB;

    // Stalled write then read, then back-to-back loads
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    check_eq("count_two", {16'b0, access_count}, 32'd2);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);

    // Prefill a working set, then random traffic with random fetches and gaps
    for (int i = 0; i < 16; i++) do_access(1'b0, 1'b1, addrs[i], $urandom);
    for (int n = 0; n < 48; n++) begin
      sel = $urandom_range(0, 15);
      instr_address = IB + 32'(sel * 4);
      #1;
      check_eq("fetch_rand", instr_readdata, iref[sel]);
      if ($urandom_range(0, 1) == 0)
        do_access(1'b1, 1'b0, addrs[$urandom_range(0, 15)], 32'h0);
      else
        do_access(1'b0, 1'b1, addrs[$urandom_range(0, 15)], $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    instr_address = IB;

    // Misaligned write leaves word 0 untouched
    do_reset();
    do_access(1'b0, 1'b1, DB + 32'h2, 32'h12345678);
    do_access(1'b1, 1'b0, DB, 32'h0);

    // Read one past the last word
    do_reset();
    do_access(1'b1, 1'b0, DB + 32'(DWORDS * 4), 32'h0);

    // Read+write conflict behaves as a write
    do_reset();
    do_access(1'b1, 1'b1, 32'h20, $urandom);
    do_access(1'b1, 1'b0, 32'h20, 32'h0);

    // Reset during a pending write aborts it
    do_reset();
    do_access(1'b0, 1'b1, 32'h24, 32'hA5A5_0001);
    data_write = 1'b1;
    data_address = 32'h24;
    data_writedata = 32'h5A5A_0002;
    repeat (EW / 2) begin
      @(posedge clk); #1;
    end
    do_reset();
    do_access(1'b1, 1'b0, 32'h24, 32'h0);

    // Request withdrawn after one cycle
    do_reset();
    v1 = $urandom;
    v2 = ~v1;
    do_access(1'b0, 1'b1, 32'h28, v1);
    data_write = 1'b1;
    data_address = 32'h28;
    data_writedata = v2;
    @(posedge clk); #1;
    data_write = 1'b0;
    @(posedge clk); #1;
    if (EW <= 1) exp_count = exp_count + 16'd1;
    if (EW == 0) ref_mem[32'h28 >> 2] = v2;
    if (EW >= 2) exp_err = 1'b1;
    check_eq("drop_count", {16'b0, access_count}, {16'b0, exp_count});
    check_eq("drop_err", {31'b0, err}, {31'b0, exp_err});
    do_access(1'b1, 1'b0, 32'h28, 32'h0);

    // Bad fetch addresses
    do_reset();
    instr_address = IB + 32'h2;
    #1;
    check_eq("fetch_misaligned", instr_readdata, 32'h0);
    @(posedge clk); #1;
    check_eq("fetch_err", {31'b0, err}, 32'd1);
    instr_address = IB + 32'(IWORDS * 4);
    #1;
    check_eq("fetch_range", instr_readdata, 32'h0);
    instr_address = IB;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
